// File: rtl/ds1302_pkg.sv
// ds1302_pkg: shared constants for the DS1302 sequencing controller.
//   - register command bytes (write form, read form is addr | 1)
//   - write-protect control values
//   - per-register read masks
//   - controller FSM state encoding
//   - helpers mapping the 3-bit register index (0=sec .. 6=year) to
//     its command byte and read mask
package ds1302_pkg;

  localparam logic [7:0] REG_SEC   = 8'h80;
  localparam logic [7:0] REG_MIN   = 8'h82;
  localparam logic [7:0] REG_HOUR  = 8'h84;
  localparam logic [7:0] REG_DATE  = 8'h86;
  localparam logic [7:0] REG_MONTH = 8'h88;
  localparam logic [7:0] REG_WEEK  = 8'h8A;
  localparam logic [7:0] REG_YEAR  = 8'h8C;
  localparam logic [7:0] REG_CTRL  = 8'h8E;

  localparam logic [7:0] WP_OFF_VAL = 8'h00;
  localparam logic [7:0] WP_ON_VAL  = 8'h80;

  localparam logic [7:0] MASK_SEC   = 8'h7F;
  localparam logic [7:0] MASK_MIN   = 8'h7F;
  localparam logic [7:0] MASK_HOUR  = 8'h3F;
  localparam logic [7:0] MASK_DATE  = 8'h3F;
  localparam logic [7:0] MASK_MONTH = 8'h1F;
  localparam logic [7:0] MASK_WEEK  = 8'h07;
  localparam logic [7:0] MASK_YEAR  = 8'hFF;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WP_OFF   = 3'd1;
  localparam logic [2:0] S_SET_REG  = 3'd2;
  localparam logic [2:0] S_WP_ON    = 3'd3;
  localparam logic [2:0] S_RD_REG   = 3'd4;
  localparam logic [2:0] S_COMMIT   = 3'd5;
  localparam logic [2:0] S_WAIT_ACK = 3'd6;

  localparam logic [2:0] LAST_IDX = 3'd6;

  function automatic logic [7:0] reg_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return REG_SEC;
      3'd1:    return REG_MIN;
      3'd2:    return REG_HOUR;
      3'd3:    return REG_DATE;
      3'd4:    return REG_MONTH;
      3'd5:    return REG_WEEK;
      3'd6:    return REG_YEAR;
      default: return REG_CTRL;
    endcase
  endfunction

  function automatic logic [7:0] rd_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    return MASK_SEC;
      3'd1:    return MASK_MIN;
      3'd2:    return MASK_HOUR;
      3'd3:    return MASK_DATE;
      3'd4:    return MASK_MONTH;
      3'd5:    return MASK_WEEK;
      default: return MASK_YEAR;
    endcase
  endfunction

endpackage

// File: rtl/ds1302_tick.sv
// ds1302_tick: free-running interval counter.
//   clk   - system clock
//   rst_n - asynchronous active-low reset (counter to 0)
//   wrap  - high for the single cycle in which count == INTERVAL-1;
//           the counter returns to 0 on the following edge
module ds1302_tick #(
  parameter logic [23:0] INTERVAL = 24'd5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap
);

  logic [23:0] count;

  assign wrap = (count == INTERVAL - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (wrap)
      count <= '0;
    else
      count <= count + 24'd1;
  end

endmodule

// File: rtl/ds1302_ctrl.sv
// ds1302_ctrl: sequences one-byte DS1302 engine commands to keep a BCD
// calendar snapshot refreshed and to load a new time on request.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   set_req / set_time          - load request and BCD {yr,wk,mo,dt,hr,mi,se}
//   cmd_read / cmd_read_ack     - read request to engine and its done pulse
//   cmd_write / cmd_write_ack   - write request to engine and its done pulse
//   read_addr, write_addr       - command bytes for the pending request
//   read_data / write_data      - engine read result / byte to write
//   sec..year                   - committed BCD snapshot
//   time_valid, set_ack, err    - one-cycle status pulses
//   busy                        - a sequence is in progress
module ds1302_ctrl
  import ds1302_pkg::*;
#(
  parameter logic [23:0] READ_INTERVAL = 24'd5_000_000,
  parameter logic [19:0] CMD_TIMEOUT   = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_req,
  input  logic [55:0] set_time,
  output logic        cmd_read,
  output logic        cmd_write,
  input  logic        cmd_read_ack,
  input  logic        cmd_write_ack,
  output logic [7:0]  read_addr,
  output logic [7:0]  write_addr,
  input  logic [7:0]  read_data,
  output logic [7:0]  write_data,
  output logic [7:0]  sec,
  output logic [7:0]  min,
  output logic [7:0]  hour,
  output logic [7:0]  date,
  output logic [7:0]  month,
  output logic [7:0]  week,
  output logic [7:0]  year,
  output logic        time_valid,
  output logic        set_ack,
  output logic        busy,
  output logic        err
);

  logic        tick_wrap;
  logic [2:0]  state;
  logic [2:0]  ret_state;
  logic [2:0]  idx;
  logic        set_pend;
  logic        rd_pend;
  logic [55:0] set_buf;
  logic [7:0]  shadow [0:5];
  logic [19:0] timer;
  logic        ack_seen;
  logic [7:0]  rd_byte;
  logic [7:0]  set_byte;

  ds1302_tick #(.INTERVAL(READ_INTERVAL)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .wrap (tick_wrap)
  );

  assign ack_seen = (cmd_read & cmd_read_ack) | (cmd_write & cmd_write_ack);
  assign rd_byte  = read_data & rd_mask(idx);

  // Clock-halt (sec) and 12/24 (hour) bits are always written as 0.
  always_comb begin
    set_byte = set_buf[{idx, 3'b000} +: 8];
    if (idx == 3'd0 || idx == 3'd2)
      set_byte[7] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      idx        <= '0;
      set_pend   <= 1'b0;
      rd_pend    <= 1'b0;
      set_buf    <= '0;
      timer      <= '0;
      cmd_read   <= 1'b0;
      cmd_write  <= 1'b0;
      read_addr  <= '0;
      write_addr <= '0;
      write_data <= '0;
      sec        <= '0;
      min        <= '0;
      hour       <= '0;
      date       <= '0;
      month      <= '0;
      week       <= '0;
      year       <= '0;
      time_valid <= 1'b0;
      set_ack    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < 6; i++) shadow[i] <= '0;
    end else begin
      time_valid <= 1'b0;
      set_ack    <= 1'b0;
      err        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (set_pend) begin
            set_pend <= 1'b0;
            busy     <= 1'b1;
            state    <= S_WP_OFF;
          end else if (rd_pend) begin
            rd_pend <= 1'b0;
            busy    <= 1'b1;
            idx     <= '0;
            state   <= S_RD_REG;
          end
        end

        S_WP_OFF: begin
          cmd_write  <= 1'b1;
          write_addr <= REG_CTRL;
          write_data <= WP_OFF_VAL;
          // WAIT_ACK always increments idx; 7 rolls over to 0 for sec.
          idx        <= 3'd7;
          ret_state  <= S_SET_REG;
          timer      <= '0;
          state      <= S_WAIT_ACK;
        end

        S_SET_REG: begin
          cmd_write  <= 1'b1;
          write_addr <= reg_cmd(idx);
          write_data <= set_byte;
          ret_state  <= (idx == LAST_IDX) ? S_WP_ON : S_SET_REG;
          timer      <= '0;
          state      <= S_WAIT_ACK;
        end

        S_WP_ON: begin
          cmd_write  <= 1'b1;
          write_addr <= REG_CTRL;
          write_data <= WP_ON_VAL;
          // Returning to IDLE from WAIT_ACK marks the end of a set sequence.
          ret_state  <= S_IDLE;
          timer      <= '0;
          state      <= S_WAIT_ACK;
        end

        S_RD_REG: begin
          cmd_read  <= 1'b1;
          read_addr <= reg_cmd(idx) | 8'h01;
          ret_state <= (idx == LAST_IDX) ? S_COMMIT : S_RD_REG;
          timer     <= '0;
          state     <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (ack_seen) begin
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            idx       <= idx + 3'd1;
            state     <= ret_state;
            if (cmd_read) begin
              if (ret_state == S_COMMIT) begin
                // The whole snapshot is published on the COMMIT entry edge
                // so time_valid and the new values appear together one
                // cycle after the last ack.
                sec        <= shadow[0];
                min        <= shadow[1];
                hour       <= shadow[2];
                date       <= shadow[3];
                month      <= shadow[4];
                week       <= shadow[5];
                year       <= rd_byte;
                time_valid <= 1'b1;
              end else begin
                for (int i = 0; i < 6; i++)
                  if (idx == 3'(i)) shadow[i] <= rd_byte;
              end
            end
            if (ret_state == S_IDLE) begin
              set_ack <= 1'b1;
              busy    <= 1'b0;
              rd_pend <= 1'b1;
            end
          end else if (timer == CMD_TIMEOUT - 20'd1) begin
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            err       <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            timer <= timer + 20'd1;
          end
        end

        S_COMMIT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      // Requests are recorded after the FSM so a same-cycle wrap or
      // set_req is never lost to IDLE clearing its pending flag.
      if (tick_wrap)
        rd_pend <= 1'b1;
      if (set_req) begin
        set_pend <= 1'b1;
        set_buf  <= set_time;
      end
    end
  end

endmodule

// File: tb/tb_ds1302_ctrl.sv
module tb_ds1302_ctrl;

  localparam logic [23:0] RI      = 24'd300;
  localparam logic [19:0] TO      = 20'd60;
  localparam int          ENG_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_req = 1'b0;
  logic [55:0] set_time = '0;
  logic        cmd_read, cmd_write;
  logic        cmd_read_ack, cmd_write_ack;
  logic [7:0]  read_addr, write_addr, read_data, write_data;
  logic [7:0]  sec, min, hour, date, month, week, year;
  logic        time_valid, set_ack, busy, err;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    longint     t;
  } txn_t;

  txn_t       log_q[$];
  logic [7:0] rd_table [0:7];
  logic       hang_en = 1'b0;
  logic       eng_busy;
  int         eng_cnt;

  int     n_chk = 0;
  int     n_fail = 0;
  int     tv_cnt = 0;
  int     sa_cnt = 0;
  int     err_cnt = 0;
  longint sa_time = 0;

  ds1302_ctrl #(.READ_INTERVAL(RI), .CMD_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_req      (set_req),
    .set_time     (set_time),
    .cmd_read     (cmd_read),
    .cmd_write    (cmd_write),
    .cmd_read_ack (cmd_read_ack),
    .cmd_write_ack(cmd_write_ack),
    .read_addr    (read_addr),
    .write_addr   (write_addr),
    .read_data    (read_data),
    .write_data   (write_data),
    .sec          (sec),
    .min          (min),
    .hour         (hour),
    .date         (date),
    .month        (month),
    .week         (week),
    .year         (year),
    .time_valid   (time_valid),
    .set_ack      (set_ack),
    .busy         (busy),
    .err          (err)
  );

  initial forever #5 clk = ~clk;

  // Behavioural engine: logs each command, acks ENG_LAT+1 cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy      <= 1'b0;
      eng_cnt       <= 0;
      cmd_read_ack  <= 1'b0;
      cmd_write_ack <= 1'b0;
      read_data     <= 8'h00;
    end else begin
      cmd_read_ack  <= 1'b0;
      cmd_write_ack <= 1'b0;
      if (!eng_busy) begin
        if ((cmd_read || cmd_write) && !cmd_read_ack && !cmd_write_ack) begin
          eng_busy <= 1'b1;
          eng_cnt  <= 1;
          log_q.push_back('{cmd_write, cmd_write ? write_addr : read_addr,
                            cmd_write ? write_data : 8'h00, longint'($time)});
          $display("txn t=%0t %s addr=%02h data=%02h", $time,
                   cmd_write ? "WR" : "RD", cmd_write ? write_addr : read_addr,
                   cmd_write ? write_data : rd_table[read_addr[3:1]]);
        end
      end else if (!(cmd_read || cmd_write)) begin
        eng_busy <= 1'b0;
      end else if (eng_cnt == ENG_LAT) begin
        if (!(cmd_read && hang_en && read_addr == 8'h85)) begin
          eng_busy <= 1'b0;
          if (cmd_read) begin
            cmd_read_ack <= 1'b1;
            read_data    <= rd_table[read_addr[3:1]];
          end else begin
            cmd_write_ack <= 1'b1;
          end
        end
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (time_valid) tv_cnt++;
    if (err) err_cnt++;
    if (set_ack) begin
      sa_cnt++;
      sa_time = longint'($time);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_txn(input string tag, input int i, input logic wr,
                           input logic [7:0] addr, input logic [7:0] data);
    logic [16:0] obs;
    obs = (i < log_q.size()) ? {log_q[i].wr, log_q[i].addr, log_q[i].data} : 17'h1FFFF;
    check(tag, obs, {wr, addr, wr ? data : 8'h00});
  endtask

  task automatic wait_tv(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (tv_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, tv_cnt >= target, 1);
  endtask

  initial begin
    int         base, k, d, tv0, sa0, er0;
    longint     t_rel;
    logic [7:0] ea [0:8];
    logic [7:0] ed [0:8];
    logic [7:0] exp_a;

    rd_table = '{8'h59, 8'h30, 8'h23, 8'h31, 8'h12, 8'h07, 8'h24, 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_read", cmd_read, 0);
    check("rst_cmd_write", cmd_write, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_sec_year", {sec, year, busy, time_valid}, 0);

    // Power-up: first refresh one interval after release
    rst_n = 1'b1;
    t_rel = longint'($time);
    base  = log_q.size();
    tv0   = tv_cnt;
    k = 0;
    while (log_q.size() <= base && k < 400) begin @(negedge clk); k++; end
    check("s1_first_rd_seen", log_q.size() > base, 1);
    d = (log_q.size() > base) ? int'((log_q[base].t - t_rel) / 10) : 0;
    check("s1_first_rd_delay", d >= int'(RI) && d <= int'(RI) + 4, 1);
    wait_tv(tv0 + 1, 200, "s1_tv");
    repeat (5) @(negedge clk);
    check("s1_tv_once", tv_cnt - tv0, 1);
    for (int i = 0; i < 7; i++) begin
      exp_a = 8'h81 + 8'(2 * i);
      check_txn("s1_rd", base + i, 1'b0, exp_a, 8'h00);
    end
    check("s1_time", {year, week, month, date, hour, min, sec}, 56'h24_07_12_31_23_30_59);
    check("s1_busy_low", busy, 0);

    // Set sequence
    ea = '{8'h8E, 8'h80, 8'h82, 8'h84, 8'h86, 8'h88, 8'h8A, 8'h8C, 8'h8E};
    ed = '{8'h00, 8'h0A, 8'h20, 8'h10, 8'h15, 8'h06, 8'h03, 8'h24, 8'h80};
    tv0 = tv_cnt; sa0 = sa_cnt; base = log_q.size();
    set_time = 56'h24_03_06_15_10_20_8A;
    set_req = 1'b1; @(negedge clk); set_req = 1'b0;
    wait_tv(tv0 + 1, 400, "s2_tv");
    repeat (5) @(negedge clk);
    check("s2_set_ack_once", sa_cnt - sa0, 1);
    for (int i = 0; i < 9; i++) check_txn("s2_wr", base + i, 1'b1, ea[i], ed[i]);
    check("s2_ack_before_read", (log_q.size() > base + 9) && (sa_time < log_q[base + 9].t), 1);
    for (int i = 0; i < 7; i++) begin
      exp_a = 8'h81 + 8'(2 * i);
      check_txn("s2_rd", base + 9 + i, 1'b0, exp_a, 8'h00);
    end
    check("s2_log_len", log_q.size() - base, 16);

    // Read masking
    rd_table[0] = 8'hD9;
    rd_table[2] = 8'hE3;
    tv0 = tv_cnt;
    wait_tv(tv0 + 1, 400, "s3_tv");
    @(negedge clk);
    check("s3_sec_masked", sec, 8'h59);
    check("s3_hour_masked", hour, 8'h23);
    check("s3_min", min, 8'h30);

    // set_req coincident with an interval wrap: set first, one read after
    tv0 = tv_cnt; base = log_q.size();
    k = 0;
    while (dut.tick_wrap !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    check("s4_wrap_seen", dut.tick_wrap, 1);
    set_time = 56'h30_05_09_28_22_45_99;
    set_req = 1'b1; @(negedge clk); set_req = 1'b0;
    wait_tv(tv0 + 1, 400, "s4_tv");
    repeat (20) @(negedge clk);
    check("s4_tv_once", tv_cnt - tv0, 1);
    check("s4_log_len", log_q.size() - base, 16);
    check_txn("s4_wp_off", base, 1'b1, 8'h8E, 8'h00);
    check_txn("s4_sec_ch", base + 1, 1'b1, 8'h80, 8'h19);
    check_txn("s4_hour", base + 3, 1'b1, 8'h84, 8'h22);
    check_txn("s4_wp_on", base + 8, 1'b1, 8'h8E, 8'h80);
    check_txn("s4_rd_after", base + 9, 1'b0, 8'h81, 8'h00);

    // Two set_req mid-read: read finishes, last set_time used, read follows
    tv0 = tv_cnt; base = log_q.size();
    k = 0;
    while (cmd_read !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    check("s4b_read_seen", cmd_read, 1);
    set_time = 56'h11_02_03_04_05_06_07;
    set_req = 1'b1; @(negedge clk); set_req = 1'b0;
    repeat (6) @(negedge clk);
    set_time = 56'h25_01_12_31_23_59_45;
    set_req = 1'b1; @(negedge clk); set_req = 1'b0;
    wait_tv(tv0 + 2, 600, "s4b_tv");
    repeat (5) @(negedge clk);
    check_txn("s4b_rd0", base, 1'b0, 8'h81, 8'h00);
    check_txn("s4b_rd6", base + 6, 1'b0, 8'h8D, 8'h00);
    check_txn("s4b_wp_off", base + 7, 1'b1, 8'h8E, 8'h00);
    check_txn("s4b_sec", base + 8, 1'b1, 8'h80, 8'h45);
    check_txn("s4b_min", base + 9, 1'b1, 8'h82, 8'h59);
    check_txn("s4b_hour", base + 10, 1'b1, 8'h84, 8'h23);
    check_txn("s4b_year", base + 14, 1'b1, 8'h8C, 8'h25);
    check_txn("s4b_wp_on", base + 15, 1'b1, 8'h8E, 8'h80);
    check_txn("s4b_rd_after", base + 16, 1'b0, 8'h81, 8'h00);
    check("s4b_log_len", log_q.size() - base, 23);

    // Ack timeout on the 3rd read
    rd_table[0] = 8'h11;
    hang_en = 1'b1;
    tv0 = tv_cnt; er0 = err_cnt;
    k = 0;
    while (err_cnt == er0 && k < 600) begin @(negedge clk); k++; end
    @(negedge clk);
    check("s5_err_once", err_cnt - er0, 1);
    check("s5_no_tv", tv_cnt - tv0, 0);
    check("s5_time_kept", {year, hour, sec}, 24'h24_23_59);
    check("s5_idle", {busy, cmd_read, cmd_write}, 0);
    hang_en = 1'b0;

    // Reset in the middle of a write
    set_time = 56'h30_05_09_28_22_45_99;
    set_req = 1'b1; @(negedge clk); set_req = 1'b0;
    k = 0;
    while (cmd_write !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("s6_write_seen", {cmd_write, busy}, 2'b11);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("s6_rst_cmd", {cmd_write, cmd_read, write_addr, write_data}, 0);
    check("s6_rst_time", {year, week, month, date, hour, min, sec}, 0);
    check("s6_rst_flags", {busy, set_ack, time_valid, err}, 0);
    rst_n = 1'b1;
    t_rel = longint'($time);
    base = log_q.size();
    tv0 = tv_cnt;
    k = 0;
    while (log_q.size() <= base && k < 400) begin @(negedge clk); k++; end
    check_txn("s6_first_is_read", base, 1'b0, 8'h81, 8'h00);
    d = (log_q.size() > base) ? int'((log_q[base].t - t_rel) / 10) : 0;
    check("s6_first_rd_delay", d >= int'(RI) && d <= int'(RI) + 4, 1);
    wait_tv(tv0 + 1, 200, "s6_tv");
    @(negedge clk);
    check("s6_time", {sec, hour}, 16'h11_23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
